grade_vector_tx: RTL and testbench

//   Transmit side of the grading path: holds a host-loaded table of test vectors
//   (instruction word + expected Result) and streams them beat by beat to the

---
 rtl/grade_vector_tx_if.sv | 27 ++
 rtl/grade_vector_tx.sv | 158 +++++++++++++++
 tb/tb_grade_vector_tx.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grade_vector_tx_if.sv
// Beat stream from the vector table to the fetch side and result checker.
interface grade_vector_tx_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_instr;
  logic [DATA_W-1:0] tx_expect;
  logic [ADDR_W-1:0] tx_seq;

  modport master (
    output tx_valid,
    output tx_instr,
    output tx_expect,
    output tx_seq,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_instr,
    input  tx_expect,
    input  tx_seq,
    output tx_ready
  );
endinterface

// File: rtl/grade_vector_tx.sv
// Host-loaded test vector table streamed out beat by beat over a valid/ready handshake.
module grade_vector_tx #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_en,
  input  logic [ADDR_W-1:0]    load_addr,
  input  logic [DATA_W-1:0]    load_instr,
  input  logic [DATA_W-1:0]    load_expect,
  input  logic [ADDR_W:0]      vec_count,
  input  logic                 start,
  input  logic                 abort,
  grade_vector_tx_if.master    tx,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      beats_sent
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] SEQ_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] expect_q, expect_d;
  logic [ADDR_W-1:0] seq_q, seq_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   sent_q, sent_d;

  logic [DATA_W-1:0] instr_mem  [DEPTH];
  logic [DATA_W-1:0] expect_mem [DEPTH];

  logic              handshake;
  logic              last_beat;
  logic [ADDR_W:0]   clamped_count;
  logic [ADDR_W-1:0] next_seq;
  logic [DATA_W-1:0] first_instr;
  logic [DATA_W-1:0] first_expect;

  assign handshake     = valid_q & tx.tx_ready;
  assign last_beat     = ({1'b0, seq_q} == (count_q - CNT_ONE));
  assign clamped_count = (vec_count > DEPTH_W) ? DEPTH_W : vec_count;
  assign next_seq      = seq_q + SEQ_ONE;

  // A write to entry 0 in the start cycle must be what beat 0 carries.
  assign first_instr  = (load_en && load_addr == '0) ? load_instr  : instr_mem[0];
  assign first_expect = (load_en && load_addr == '0) ? load_expect : expect_mem[0];

  always_ff @(posedge clk) begin
    if (state_q == IDLE && load_en) begin
      instr_mem[load_addr]  <= load_instr;
      expect_mem[load_addr] <= load_expect;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      instr_q  <= '0;
      expect_q <= '0;
      seq_q    <= '0;
      count_q  <= '0;
      sent_q   <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      instr_q  <= instr_d;
      expect_q <= expect_d;
      seq_q    <= seq_d;
      count_q  <= count_d;
      sent_q   <= sent_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    instr_d  = instr_q;
    expect_d = expect_q;
    seq_d    = seq_q;
    count_d  = count_q;
    sent_d   = sent_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sent_d = '0;
          if (clamped_count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = RUN;
            count_d  = clamped_count;
            valid_d  = 1'b1;
            busy_d   = 1'b1;
            seq_d    = '0;
            instr_d  = first_instr;
            expect_d = first_expect;
          end
        end
      end
      RUN: begin
        // A beat accepted in the abort cycle still counts.
        if (handshake) begin
          sent_d = sent_q + CNT_ONE;
        end
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (handshake) begin
          if (last_beat) begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            seq_d    = next_seq;
            instr_d  = instr_mem[next_seq];
            expect_d = expect_mem[next_seq];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx.tx_valid  = valid_q;
  assign tx.tx_instr  = instr_q;
  assign tx.tx_expect = expect_q;
  assign tx.tx_seq    = seq_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign beats_sent   = sent_q;

endmodule

// File: tb/tb_grade_vector_tx.sv
// Directed bench for grade_vector_tx; a queue of expected beats is checked as beats are accepted.
module tb_grade_vector_tx;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] seq;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] exp;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_instr;
  logic [DATA_W-1:0] load_expect;
  logic [ADDR_W:0]   vec_count;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   beats_sent;

  grade_vector_tx_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) tx_bus ();

  grade_vector_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_instr  (load_instr),
    .load_expect (load_expect),
    .vec_count   (vec_count),
    .start       (start),
    .abort       (abort),
    .tx          (tx_bus),
    .busy        (busy),
    .done        (done),
    .beats_sent  (beats_sent)
  );

  always #5 clk = ~clk;

  beat_t             sb_q [$];
  beat_t             mon_beat;
  logic [DATA_W-1:0] instr_tab [DEPTH];
  logic [DATA_W-1:0] exp_tab   [DEPTH];
  int                checks   = 0;
  int                failures = 0;
  int                done_cnt = 0;
  logic [ADDR_W-1:0] last_seq = '0;
  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] stall_instr;
  logic [DATA_W-1:0] stall_exp;
  logic [ADDR_W-1:0] stall_seq;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beats are judged on the falling edge, where valid/ready match what the next rising edge sees.
  always @(negedge clk) begin
    if (reset) begin
      if (tx_bus.tx_valid && stall_prev) begin
        check_output("stall_seq",    tx_bus.tx_seq,    stall_seq);
        check_output("stall_instr",  tx_bus.tx_instr,  stall_instr);
        check_output("stall_expect", tx_bus.tx_expect, stall_exp);
      end
      if (tx_bus.tx_valid && tx_bus.tx_ready) begin
        check_output("beat_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          mon_beat = sb_q.pop_front();
          check_output("beat_seq",    tx_bus.tx_seq,    mon_beat.seq);
          check_output("beat_instr",  tx_bus.tx_instr,  mon_beat.instr);
          check_output("beat_expect", tx_bus.tx_expect, mon_beat.exp);
        end
        last_seq = tx_bus.tx_seq;
      end
      stall_prev  = tx_bus.tx_valid && !tx_bus.tx_ready;
      stall_seq   = tx_bus.tx_seq;
      stall_instr = tx_bus.tx_instr;
      stall_exp   = tx_bus.tx_expect;
      if (done) done_cnt++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus_load(input int addr, input logic [DATA_W-1:0] instr,
                                     input logic [DATA_W-1:0] exp);
    load_en     = 1'b1;
    load_addr   = ADDR_W'(addr);
    load_instr  = instr;
    load_expect = exp;
    instr_tab[addr] = instr;
    exp_tab[addr]   = exp;
    tick();
    load_en = 1'b0;
  endtask

  task automatic push_run(input int n);
    int m;
    m = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < m; i++) begin
      sb_q.push_back('{ADDR_W'(i), instr_tab[i], exp_tab[i]});
    end
  endtask

  task automatic apply_stimulus_start(input int n);
    vec_count = (ADDR_W+1)'(n);
    start     = 1'b1;
    push_run(n);
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int max_cycles, input bit backpressure, output int cycles);
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    while (!done && k < max_cycles) begin
      if (backpressure) tx_bus.tx_ready = pat[k % 4];
      tick();
      k++;
    end
    check_output("done_within_budget", k < max_cycles, 1);
    cycles = k;
  endtask

  initial begin
    int cycles;
    int done_base;
    logic [DATA_W-1:0] v_instr;
    logic [DATA_W-1:0] v_exp;

    reset = 1'b0; load_en = 1'b0; load_addr = '0; load_instr = '0; load_expect = '0;
    vec_count = '0; start = 1'b0; abort = 1'b0; tx_bus.tx_ready = 1'b0;

    $display("[TB] T1 reset");
    repeat (3) tick();
    check_output("rst_valid", tx_bus.tx_valid, 0);
    check_output("rst_busy",  busy, 0);
    check_output("rst_done",  done, 0);
    check_output("rst_beats", beats_sent, 0);
    check_output("rst_seq",   tx_bus.tx_seq, 0);
    reset = 1'b1;
    tick();

    $display("[TB] T2 load table and stream 20 beats");
    for (int i = 0; i < DEPTH; i++) begin
      v_instr = 32'h0000_4024 | (32'(i) << 21);
      v_exp   = (i == 19) ? 32'h0000_0030 : 32'(i * 3);
      apply_stimulus_load(i, v_instr, v_exp);
    end
    tx_bus.tx_ready = 1'b1;
    done_base = done_cnt;
    vec_count = 6'd20;
    start = 1'b1;
    push_run(20);
    check_output("valid_before_start", tx_bus.tx_valid, 0);
    tick();
    start = 1'b0;
    check_output("valid_latency", tx_bus.tx_valid, 1);
    check_output("busy_in_run", busy, 1);
    check_output("first_seq", tx_bus.tx_seq, 0);
    run_until_done(100, 1'b0, cycles);
    check_output("t2_cycles", cycles, 20);
    check_output("t2_beats", beats_sent, 20);
    check_output("t2_busy_done", busy, 0);
    tick();
    check_output("t2_done_one_cycle", done, 0);
    check_output("t2_done_count", done_cnt - done_base, 1);
    check_output("t2_sb_empty", sb_q.size(), 0);

    $display("[TB] T3 back-pressure");
    done_base = done_cnt;
    tx_bus.tx_ready = 1'b1;
    apply_stimulus_start(20);
    run_until_done(200, 1'b1, cycles);
    check_output("t3_beats", beats_sent, 20);
    tick();
    check_output("t3_done_count", done_cnt - done_base, 1);
    check_output("t3_sb_empty", sb_q.size(), 0);

    $display("[TB] T4 zero and oversized counts");
    tx_bus.tx_ready = 1'b1;
    done_base = done_cnt;
    apply_stimulus_start(0);
    check_output("t4_zero_done", done, 1);
    check_output("t4_zero_valid", tx_bus.tx_valid, 0);
    check_output("t4_zero_beats", beats_sent, 0);
    tick();
    check_output("t4_zero_done_drop", done, 0);
    check_output("t4_zero_done_count", done_cnt - done_base, 1);
    apply_stimulus_start(40);
    run_until_done(100, 1'b0, cycles);
    check_output("t4_clamp_cycles", cycles, 32);
    check_output("t4_clamp_beats", beats_sent, 32);
    check_output("t4_clamp_last_seq", last_seq, 31);
    tick();
    check_output("t4_sb_empty", sb_q.size(), 0);

    $display("[TB] T5 abort");
    tx_bus.tx_ready = 1'b1;
    done_base = done_cnt;
    apply_stimulus_start(20);
    repeat (5) tick();
    check_output("t5_pre_beats", beats_sent, 5);
    check_output("t5_pre_seq", tx_bus.tx_seq, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("t5_abort_valid", tx_bus.tx_valid, 0);
    check_output("t5_abort_beats_hs", beats_sent, 6);
    check_output("t5_abort_busy", busy, 0);
    check_output("t5_sb_left", sb_q.size(), 14);
    sb_q.delete();
    repeat (3) tick();
    check_output("t5_no_done", done_cnt - done_base, 0);
    apply_stimulus_start(20);
    check_output("t5_restart_seq", tx_bus.tx_seq, 0);
    check_output("t5_restart_valid", tx_bus.tx_valid, 1);
    repeat (5) tick();
    tx_bus.tx_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("t5_abort_beats_nohs", beats_sent, 5);
    check_output("t5_abort2_valid", tx_bus.tx_valid, 0);
    check_output("t5_sb_left2", sb_q.size(), 15);
    sb_q.delete();
    tick();
    check_output("t5_no_done2", done_cnt - done_base, 0);

    $display("[TB] T6 load/start while busy, load+start same cycle, reset mid-run");
    tx_bus.tx_ready = 1'b1;
    apply_stimulus_start(20);
    repeat (3) tick();
    load_en = 1'b1; load_addr = 5'd10; load_instr = 32'hDEAD_BEEF; load_expect = 32'hFFFF_FFFF;
    start = 1'b1; vec_count = 6'd5;
    tick();
    load_en = 1'b0; start = 1'b0;
    run_until_done(100, 1'b0, cycles);
    check_output("t6_busy_beats", beats_sent, 20);
    tick();
    check_output("t6_busy_sb_empty", sb_q.size(), 0);

    load_en = 1'b1; load_addr = '0; load_instr = 32'hA5A5_0001; load_expect = 32'h0000_005A;
    instr_tab[0] = 32'hA5A5_0001;
    exp_tab[0]   = 32'h0000_005A;
    apply_stimulus_start(1);
    load_en = 1'b0;
    check_output("t6_bypass_instr", tx_bus.tx_instr, 32'hA5A5_0001);
    run_until_done(20, 1'b0, cycles);
    check_output("t6_bypass_beats", beats_sent, 1);
    tick();

    done_base = done_cnt;
    apply_stimulus_start(20);
    repeat (4) tick();
    #2 reset = 1'b0;
    #1;
    check_output("t6_arst_valid", tx_bus.tx_valid, 0);
    check_output("t6_arst_busy", busy, 0);
    check_output("t6_arst_done", done, 0);
    check_output("t6_arst_beats", beats_sent, 0);
    check_output("t6_arst_seq", tx_bus.tx_seq, 0);
    check_output("t6_arst_instr", tx_bus.tx_instr, 0);
    sb_q.delete();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check_output("t6_arst_no_done", done_cnt - done_base, 0);
    check_output("t6_arst_idle", busy, 0);
    apply_stimulus_start(2);
    run_until_done(20, 1'b0, cycles);
    check_output("t6_table_kept_beats", beats_sent, 2);
    tick();
    check_output("t6_table_kept_sb", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
